// File: rtl/count_display_pkg.sv
// count_display_pkg: shared types and constants for the count_display block.
// Holds the conversion FSM state type, width constants, the seven-segment
// lookup table (active-low {g,f,e,d,c,b,a}) and a digit-encoding helper.
package count_display_pkg;

  // Width of the binary count coming from the counter
  localparam int CNT_W = 10;
  // Four packed BCD nibbles: thousands, hundreds, tens, units
  localparam int BCD_W = 16;
  // Number of physical seven-segment digits
  localparam int DIGITS = 4;
  // Width of the digit-scan index
  localparam int IDX_W = 2;
  // One double-dabble step per input bit
  localparam int SHIFT_CYCLES = CNT_W;
  // Width of the shift-step counter (must hold SHIFT_CYCLES-1)
  localparam int SCNT_W = 4;

  // Conversion FSM states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LOAD  = 2'd2
  } conv_state_t;

  // All cathodes off
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low cathode patterns for decimal digits 0..9
  localparam logic [6:0] SEG_LUT [10] = '{
    7'h40,  // 0
    7'h79,  // 1
    7'h24,  // 2
    7'h30,  // 3
    7'h19,  // 4
    7'h12,  // 5
    7'h02,  // 6
    7'h78,  // 7
    7'h00,  // 8
    7'h10   // 9
  };

  // Encode one BCD digit; non-decimal codes show as blank rather than garbage
  function automatic logic [6:0] seg_encode(input logic [3:0] digit);
    if (digit <= 4'd9) begin
      return SEG_LUT[digit];
    end
    return SEG_BLANK;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential double-dabble binary-to-BCD converter.
// In IDLE a conversion is launched whenever start is high and bin differs
// from the last value converted. SHIFT performs one add-3/shift step per
// clock for CNT_W clocks, LOAD publishes the result on bcd and pulses done
// on the following cycle. busy is high in SHIFT and LOAD.
module bin2bcd_seq
  import count_display_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] bin,
  output logic [BCD_W-1:0] bcd,
  output logic             done,
  output logic             busy
);

  conv_state_t       state;
  logic [CNT_W-1:0]  src_reg;
  logic [CNT_W-1:0]  last_reg;
  logic [BCD_W-1:0]  work_reg;
  logic [SCNT_W-1:0] shift_cnt;
  logic [BCD_W-1:0]  work_adj;

  // Add 3 to every BCD nibble that is 5 or more before the next shift,
  // so that the shift carries correctly into the next decimal digit
  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
      assign work_adj[gi*4 +: 4] = (work_reg[gi*4 +: 4] >= 4'd5)
                                   ? work_reg[gi*4 +: 4] + 4'd3
                                   : work_reg[gi*4 +: 4];
    end
  endgenerate

  // Conversion FSM with registered bcd, done and busy outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      src_reg   <= '0;
      last_reg  <= '0;
      work_reg  <= '0;
      shift_cnt <= '0;
      bcd       <= '0;
      done      <= 1'b0;
      busy      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && (bin != last_reg)) begin
            src_reg   <= bin;
            last_reg  <= bin;
            work_reg  <= '0;
            shift_cnt <= '0;
            busy      <= 1'b1;
            state     <= SHIFT;
          end
        end
        SHIFT: begin
          // Adjusted BCD shifts left, pulling in the next binary MSB
          work_reg <= {work_adj[BCD_W-2:0], src_reg[CNT_W-1]};
          src_reg  <= {src_reg[CNT_W-2:0], 1'b0};
          if (shift_cnt == SCNT_W'(SHIFT_CYCLES - 1)) begin
            state <= LOAD;
          end else begin
            shift_cnt <= shift_cnt + SCNT_W'(1);
          end
        end
        LOAD: begin
          bcd   <= work_reg;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/count_display.sv
// count_display: converts a 10-bit count to decimal and scans it onto a
// four-digit, common-anode seven-segment display (Basys3 pinout).
// The binary-to-BCD conversion runs in bin2bcd_seq; the refresh divider,
// digit scan, digit mux and segment encoding live here.
// Optional build macro COUNT_DISPLAY_BLANK_EN: blank leading-zero digits
// (thousands, hundreds, tens); the units digit is always shown.
module count_display
  import count_display_pkg::*;
#(
  parameter int REFRESH_DIV = 100000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [CNT_W-1:0]  count_in,
  output logic [6:0]        seg,
  output logic [DIGITS-1:0] an,
  output logic              dp,
  output logic              busy
);

  localparam int DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  logic [DIV_W-1:0] div_cnt;
  logic             tick;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] idx_next;
  logic [BCD_W-1:0] conv_bcd;
  logic             conv_done;
  logic [BCD_W-1:0] bcd_reg;
  logic [DIGITS-1:0] blank;
  logic [6:0]       digit_seg [DIGITS];

  // Decimal point is never used
  assign dp = 1'b1;

  // Converter restarts on its own whenever count_in moves away from the
  // last converted value, so the request is permanently enabled
  bin2bcd_seq u_bin2bcd (
    .clk   (clk),
    .reset (reset),
    .start (1'b1),
    .bin   (count_in),
    .bcd   (conv_bcd),
    .done  (conv_done),
    .busy  (busy)
  );

  // Capture each finished conversion; the display only samples it on ticks
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bcd_reg <= '0;
    end else if (conv_done) begin
      bcd_reg <= conv_bcd;
    end
  end

  // Refresh divider: tick once every REFRESH_DIV clocks
  assign tick = (div_cnt == DIV_W'(REFRESH_DIV - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  // Leading-zero blanking mask; the units digit is never blanked
`ifdef COUNT_DISPLAY_BLANK_EN
  generate
    for (genvar gi = 1; gi < DIGITS; gi++) begin : g_blank
      if (gi == DIGITS - 1) begin : g_top
        assign blank[gi] = (bcd_reg[gi*4 +: 4] == 4'd0);
      end else begin : g_lower
        assign blank[gi] = blank[gi+1] && (bcd_reg[gi*4 +: 4] == 4'd0);
      end
    end
  endgenerate
  assign blank[0] = 1'b0;
`else
  assign blank = '0;
`endif

  // Per-digit segment pattern, ready for the scan mux
  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
      assign digit_seg[gi] = blank[gi] ? SEG_BLANK
                                       : seg_encode(bcd_reg[gi*4 +: 4]);
    end
  endgenerate

  assign idx_next = idx + IDX_W'(1);

  // Digit scan: on each tick advance idx and register the matching anode
  // and cathode pattern; idx resets to 3 so the first tick lands on digit 0
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx <= IDX_W'(DIGITS - 1);
      an  <= '1;
      seg <= SEG_BLANK;
    end else if (tick) begin
      idx <= idx_next;
      an  <= ~(DIGITS'(1) << idx_next);
      seg <= digit_seg[idx_next];
    end
  end

endmodule

// File: tb/tb_count_display.sv
// tb_count_display: self-checking bench for count_display (REFRESH_DIV=4).
// A transaction-level reference model (decimal arithmetic, conversion
// timing as busy/latency counters, scan position from the edge count)
// is compared against the DUT outputs every cycle, plus directed checks.
module tb_count_display;

  localparam int DIV = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [9:0] count_in = 10'd0;
  logic [6:0] seg;
  logic [3:0] an;
  logic       dp;
  logic       busy;

  int n_checks = 0;
  int n_pass   = 0;

  count_display #(.REFRESH_DIV(DIV)) dut (
    .clk      (clk),
    .reset    (reset),
    .count_in (count_in),
    .seg      (seg),
    .an       (an),
    .dp       (dp),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Independent cathode table, active-low {g,f,e,d,c,b,a}
  logic [6:0] seg_ref [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                               7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  // ---------------- reference model ----------------
  logic [9:0] m_last      = 10'd0;
  int         m_val       = 0;
  int         m_shown     = 0;   // decimal value currently held for display
  int         m_busy_left = 0;
  int         m_upd       = 0;
  int         m_edges     = 0;
  logic [6:0] m_seg       = 7'h7F;
  logic [3:0] m_an        = 4'hF;

  function automatic int pow10(input int e);
    int r = 1;
    for (int k = 0; k < e; k++) r = r * 10;
    return r;
  endfunction

  function automatic logic [15:0] to_bcd(input int v);
    return 16'((v / 1000) * 4096 + ((v / 100) % 10) * 256 +
               ((v / 10) % 10) * 16 + (v % 10));
  endfunction

  function automatic logic [6:0] exp_seg(input int value, input int pos);
    int digit;
    digit = (value / pow10(pos)) % 10;
`ifdef COUNT_DISPLAY_BLANK_EN
    if (pos > 0 && value < pow10(pos)) return 7'h7F;
`endif
    return seg_ref[digit];
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_last      = 10'd0;
      m_shown     = 0;
      m_busy_left = 0;
      m_upd       = 0;
      m_edges     = 0;
      m_seg       = 7'h7F;
      m_an        = 4'hF;
    end else begin
      logic [3:0] onehot;
      int         pos;
      m_edges++;
      // display sees the value held before this edge's capture
      if (m_edges % DIV == 0) begin
        pos    = ((m_edges / DIV) - 1) % 4;
        onehot = 4'b0001 << pos;
        m_an   = ~onehot;
        m_seg  = exp_seg(m_shown, pos);
      end
      if (m_upd > 0) begin
        m_upd--;
        if (m_upd == 0) begin
          m_shown = m_val;
          $display("conv %0d -> bcd %04h", m_val, to_bcd(m_val));
        end
      end
      if (m_busy_left > 0) begin
        m_busy_left--;
      end else if (count_in != m_last) begin
        m_last      = count_in;
        m_val       = int'(count_in);
        m_busy_left = 11;
        m_upd       = 12;
      end
    end
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, want, $time);
  endtask

  // Advance one cycle and compare every output against the model
  task automatic step();
    @(negedge clk);
    check("busy", 32'(busy), 32'(m_busy_left > 0));
    check("seg", 32'(seg), 32'(m_seg));
    check("an", 32'(an), 32'(m_an));
    check("dp", 32'(dp), 32'd1);
    check("bcd_reg", 32'(dut.bcd_reg), 32'(to_bcd(m_shown)));
  endtask

  // Watch 16 cycles of scanning and compare each selected digit
  task automatic scan_check(input string tag, input logic [3:0][6:0] want);
    logic [3:0] sel;
    for (int s = 0; s < 16; s++) begin
      step();
      for (int d = 0; d < 4; d++) begin
        sel = 4'b0001 << d;
        if (an == ~sel) check(tag, 32'(seg), 32'(want[d]));
      end
    end
  endtask

  initial begin
    logic [3:0] an_seq [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
    logic [3:0] an_prev;
    int         k;
    int         hold;

    // reset state
    step();
    step();
    check("rst_seg", 32'(seg), 32'h7F);
    check("rst_an", 32'(an), 32'hF);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_bcd", 32'(dut.bcd_reg), 32'd0);
    reset = 1'b0;
    $display("txn reset released, count_in=0");

    // count_in=0: no conversion, zeros displayed, anodes E,D,B,7
    an_prev = an;
    k = 0;
    for (int i = 0; i < 16; i++) begin
      step();
      check("zero_busy", 32'(busy), 32'd0);
      if (an != an_prev) begin
        check("zero_an_seq", 32'(an), 32'(an_seq[k % 4]));
        check("zero_seg", 32'(seg), 32'h40);
        k++;
      end
      an_prev = an;
    end
    check("zero_ticks", 32'(k), 32'd4);

    // 0 -> 1023: busy 11 cycles, bcd_reg at +12
    count_in = 10'd1023;
    $display("txn count_in=1023");
    for (int i = 1; i <= 13; i++) begin
      step();
      if (i <= 11) check("c1023_busy_hi", 32'(busy), 32'd1);
      if (i == 12) begin
        check("c1023_busy_lo", 32'(busy), 32'd0);
        check("c1023_bcd_pre", 32'(dut.bcd_reg), 32'h0000);
      end
      if (i == 13) check("c1023_bcd", 32'(dut.bcd_reg), 32'h1023);
    end
    repeat (4) step();
    scan_check("c1023_scan", '{7'h79, 7'h40, 7'h24, 7'h30});

    // 5, then 999 during the third busy cycle
    count_in = 10'd5;
    $display("txn count_in=5 then 999");
    for (int i = 1; i <= 25; i++) begin
      step();
      if (i == 3) count_in = 10'd999;
      if (i == 12) check("c5_bcd_pre", 32'(dut.bcd_reg), 32'h1023);
      if (i == 13) check("c5_bcd", 32'(dut.bcd_reg), 32'h0005);
      if (i == 24) check("c999_bcd_pre", 32'(dut.bcd_reg), 32'h0005);
      if (i == 25) check("c999_bcd", 32'(dut.bcd_reg), 32'h0999);
    end

    // reset in the middle of a 512 conversion
    count_in = 10'd512;
    $display("txn count_in=512 with reset mid-conversion");
    repeat (5) step();
    reset = 1'b1;
    step();
    check("abort_bcd", 32'(dut.bcd_reg), 32'h0000);
    check("abort_seg", 32'(seg), 32'h7F);
    check("abort_an", 32'(an), 32'hF);
    check("abort_busy", 32'(busy), 32'd0);
    step();
    reset = 1'b0;
    for (int i = 1; i <= 13; i++) begin
      step();
      if (i == 1) check("restart_busy", 32'(busy), 32'd1);
      if (i == 12) check("c512_bcd_pre", 32'(dut.bcd_reg), 32'h0000);
      if (i == 13) check("c512_bcd", 32'(dut.bcd_reg), 32'h0512);
    end

    // count_in=7: leading digits blank or zero depending on build
    count_in = 10'd7;
    $display("txn count_in=7");
    repeat (13) step();
    check("c7_bcd", 32'(dut.bcd_reg), 32'h0007);
    repeat (4) step();
`ifdef COUNT_DISPLAY_BLANK_EN
    scan_check("c7_scan", '{7'h7F, 7'h7F, 7'h7F, 7'h78});
`else
    scan_check("c7_scan", '{7'h40, 7'h40, 7'h40, 7'h78});
`endif

    // ramp 0..1023, one step per 20 cycles
    $display("txn ramp 0..1023");
    for (int v = 0; v < 1024; v++) begin
      count_in = 10'(v);
      repeat (20) step();
    end
    repeat (13) step();
    check("ramp_final", 32'(dut.bcd_reg), 32'h1023);

    // random values, random hold times, occasional reset pulses
    for (int t = 0; t < 150; t++) begin
      count_in = 10'($urandom_range(0, 1023));
      hold = $urandom_range(1, 30);
      $display("txn random count_in=%0d hold=%0d", count_in, hold);
      repeat (hold) step();
      if ($urandom_range(0, 19) == 0) begin
        reset = 1'b1;
        $display("txn random reset pulse");
        repeat ($urandom_range(1, 3)) step();
        reset = 1'b0;
      end
    end
    repeat (30) step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
